// File: rtl/arp_reply_tx.sv
// ARP reply transmitter: captures requester MAC/IP from the receive-path bus and,
// on a validated trigger, streams a 60-octet ARP reply frame to the TX arbiter.
module arp_reply_tx #(
  parameter logic [31:0] ip  = 32'hC0A80702,
  parameter logic [47:0] mac = 48'h125555000131
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] arp_bus,
  output logic        tx_req,
  input  logic        tx_grant,
  output logic        tx_strobe,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  output logic        busy,
  output logic [7:0]  drop_count
);

  typedef enum logic [1:0] {StIdle, StReq, StSend} state_e;

  localparam logic [5:0] LastIdx = 6'd59;

  logic       ok, strobe, wr, trigger;
  logic [7:0] wdata;

  assign ok      = arp_bus[10];
  assign strobe  = arp_bus[9];
  assign wr      = arp_bus[8];
  assign wdata   = arp_bus[7:0];
  assign trigger = strobe & ok;

  // Byte k of a buffer: 0..5 requester MAC (MSB first), 6..9 requester IP.
  logic [9:0][7:0] shadow_q, shadow_d;
  logic [9:0][7:0] tbuf_q;
  logic [3:0]      wptr_q, wptr_d;

  state_e     state_q;
  logic [5:0] cnt_q;
  logic       tx_req_q, tx_strobe_q, tx_last_q, busy_q;
  logic [7:0] tx_data_q, drop_count_q;

  assign tx_req     = tx_req_q;
  assign tx_strobe  = tx_strobe_q;
  assign tx_data    = tx_data_q;
  assign tx_last    = tx_last_q;
  assign busy       = busy_q;
  assign drop_count = drop_count_q;

  // Next shadow contents are also what a same-cycle trigger copies out.
  always_comb begin
    shadow_d = shadow_q;
    wptr_d   = 4'd0;
    if (wr) begin
      if (wptr_q < 4'd10) begin
        shadow_d[wptr_q] = wdata;
        wptr_d           = wptr_q + 4'd1;
      end else begin
        wptr_d = wptr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      wptr_q   <= 4'd0;
    end else begin
      shadow_q <= shadow_d;
      wptr_q   <= wptr_d;
    end
  end

  function automatic logic [7:0] frame_octet(input logic [5:0] idx, input logic [9:0][7:0] b);
    logic [7:0] o;
    int         i;
    o = 8'h00;
    i = int'(idx);
    if (i < 6) begin
      o = b[4'(i)];
    end else if (i < 12) begin
      o = mac[8*(11-i) +: 8];
    end else if (i < 22) begin
      case (idx)
        6'd12, 6'd16: o = 8'h08;
        6'd13, 6'd18: o = 8'h06;
        6'd15:        o = 8'h01;
        6'd19:        o = 8'h04;
        6'd21:        o = 8'h02;
        default:      o = 8'h00;
      endcase
    end else if (i < 28) begin
      o = mac[8*(27-i) +: 8];
    end else if (i < 32) begin
      o = ip[8*(31-i) +: 8];
    end else if (i < 42) begin
      o = b[4'(i-32)];
    end
    return o;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 6'd0;
      tbuf_q       <= '0;
      tx_req_q     <= 1'b0;
      tx_strobe_q  <= 1'b0;
      tx_last_q    <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      drop_count_q <= 8'h00;
    end else begin
      if (trigger && state_q != StIdle) begin
        drop_count_q <= drop_count_q + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            tbuf_q   <= shadow_d;
            state_q  <= StReq;
            tx_req_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StReq: begin
          if (tx_grant) begin
            state_q     <= StSend;
            cnt_q       <= 6'd0;
            tx_strobe_q <= 1'b1;
            tx_data_q   <= frame_octet(6'd0, tbuf_q);
            tx_last_q   <= 1'b0;
          end
        end
        StSend: begin
          // cnt_q is the index of the octet currently on tx_data.
          if (cnt_q == LastIdx) begin
            state_q     <= StIdle;
            cnt_q       <= 6'd0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            tx_strobe_q <= 1'b0;
            tx_last_q   <= 1'b0;
            tx_data_q   <= 8'h00;
          end else begin
            cnt_q     <= cnt_q + 6'd1;
            tx_data_q <= frame_octet(cnt_q + 6'd1, tbuf_q);
            tx_last_q <= (cnt_q == LastIdx - 6'd1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
